ccff_stream_loader: RTL and testbench
=====================================

CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning the bitstream word width.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 4096, meaning the total configuration-chain length in bits (1..65535).
REQ-003 The block SHALL have port prog_clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port prog_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load.
REQ-006 The block SHALL have port in_data, input, WORD_W bits: the bitstream word, shifted out LSB first.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port ccff_head, output, 1 bit: serial bit to the chain head.
REQ-010 The block SHALL have port ccff_shift_en, output, 1 bit: the chain shifts ccff_head on this prog_clk edge.
REQ-011 The block SHALL have port ccff_tail, input, 1 bit: serial bit returned from the chain tail.
REQ-012 The block SHALL have port IO_ISOL_N, output, 1 bit: I/O isolation, where 0 means the pads are isolated.
REQ-013 The block SHALL have port done, output, 1 bit: the chain is fully loaded.
REQ-014 The block SHALL have port stall_cnt, output, 16 bits: count of cycles with no data at a word boundary.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, SHIFT and DONE.
REQ-016 IDLE SHALL go to FILL on start; DONE SHALL go to FILL on start, clearing done and bit_cnt and driving IO_ISOL_N=0 on the next cycle.
REQ-017 The datapath SHALL consist of a one-word holding buffer, a shift register, a bit-in-word counter and a 16-bit bit_cnt.
REQ-018 in_ready SHALL be 1 only in FILL/SHIFT while the holding buffer is empty; a word is transferred when in_valid and in_ready are both 1.
REQ-019 FILL SHALL move the buffer into the shift register and go to SHIFT the cycle after the buffer becomes full.
REQ-020 In SHIFT, ccff_shift_en SHALL be 1, ccff_head SHALL be the shift-register bit 0, and each cycle SHALL shift right and increment bit_cnt.
REQ-021 At the last bit of a word with the buffer full, the buffer SHALL reload into the shift register in the same cycle, with no bubble.
REQ-022 At the last bit of a word with the buffer empty, the FSM SHALL go to FILL.
REQ-023 In FILL, ccff_shift_en SHALL be 0, ccff_head SHALL hold its last value, and stall_cnt SHALL increment each cycle (saturating at 0xFFFF).
REQ-024 When bit_cnt reaches CHAIN_LEN, the FSM SHALL go to DONE immediately, discarding the remaining word bits and any buffered word.
REQ-025 Exactly CHAIN_LEN cycles SHALL have ccff_shift_en=1 per load.
REQ-026 In DONE: done=1, IO_ISOL_N=1, in_ready=0, ccff_shift_en=0.
REQ-027 start SHALL be ignored in FILL and SHIFT.
REQ-028 in_valid in IDLE/DONE SHALL be ignored, with no transfer.
REQ-029 stall_cnt SHALL clear on start.

Reset
REQ-030 prog_rst_n=0 at a prog_clk edge SHALL force IDLE, empty the buffer, and clear bit_cnt, the shift register and stall_cnt, at any state including mid-shift.
REQ-031 Reset values SHALL be: in_ready=0, ccff_head=0, ccff_shift_en=0, done=0, IO_ISOL_N=0, stall_cnt=0.

Configuration
REQ-032 Macro CCFF_READBACK_EN SHALL add output tail_ones, 16 bits: count of ccff_tail=1 sampled on cycles with ccff_shift_en=1, cleared on start and reset.
REQ-033 Without CCFF_READBACK_EN, ccff_tail SHALL be unused and the port tail_ones SHALL be absent.

Structure
REQ-034 A shared package ccff_loader_pkg SHALL hold the state enum (IDLE/FILL/SHIFT/DONE), the default WORD_W/CHAIN_LEN constants, and the 16-bit counter width.
REQ-035 Sub-module ccff_word_buffer SHALL hold the one-entry valid/ready holding register; the FSM and shifter SHALL stay in the top level.

Verification
REQ-036 Streaming: CHAIN_LEN=64, WORD_W=32, words 0x0000_0001 and 0x8000_0000 presented back-to-back -> 64 consecutive ccff_shift_en cycles; ccff_head=1 at bits 0 and 63; stall_cnt=0; done=1 and IO_ISOL_N=1 the cycle after bit 63.
REQ-037 Underflow: a second word held off for 5 cycles -> ccff_shift_en=0 for 5 cycles; ccff_head stable; stall_cnt=5; total of 64 shifts.
REQ-038 Partial word: CHAIN_LEN=40 with two words -> exactly 40 shifts; bits 8..31 of word 2 are never driven; done=1.
REQ-039 Reset mid-shift: prog_rst_n=0 at bit 20 -> next cycle IDLE, IO_ISOL_N=0, ccff_shift_en=0; a restart reloads 64 bits from bit 0.
REQ-040 Restart: start in DONE -> IO_ISOL_N=0 and done=0 next cycle; start during SHIFT has no effect.
REQ-041 Readback with CCFF_READBACK_EN: chain model = 64-bit shift register preloaded with 0xFF, second load -> tail_ones=8.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain stream loader.
package ccff_loader_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_CHAIN_LEN = 4096;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ccff_word_buffer.sv
// One-entry valid/ready holding register between the bitstream source and the shifter.
module ccff_word_buffer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              accept_en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic [WORD_W-1:0] data
);

  assign in_ready = accept_en & ~full;

  // Capture a word on handshake; pop and push never coincide since push needs empty and pop needs full.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// Streams bitstream words LSB first into a configuration flip-flop chain.
// Optional: define CCFF_READBACK_EN to add the tail_ones readback counter.
module ccff_stream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              done,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef CCFF_READBACK_EN
  ,
  output logic [CNT_W-1:0]  tail_ones
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sr;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   bit_cnt;

  logic               buf_full, buf_pop, buf_flush, accept_en;
  logic [WORD_W-1:0]  buf_data;
  logic               load_sr, shift_sr, clr_load, stall_inc;

  ccff_word_buffer #(.WORD_W(WORD_W)) u_buf (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .accept_en  (accept_en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .full       (buf_full),
    .data       (buf_data)
  );

  // Next state and datapath controls. The shifter does not advance on a word's
  // last bit, so sr[0] keeps the last driven bit and ccff_head holds during stalls.
  always_comb begin
    state_d       = state_q;
    accept_en     = 1'b0;
    buf_pop       = 1'b0;
    buf_flush     = 1'b0;
    ccff_shift_en = 1'b0;
    load_sr       = 1'b0;
    shift_sr      = 1'b0;
    clr_load      = 1'b0;
    stall_inc     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = FILL;
          clr_load = 1'b1;
        end
      end
      FILL: begin
        accept_en = 1'b1;
        // Waiting for the very first word is start-up latency, not a stall.
        stall_inc = (bit_cnt != '0);
        if (buf_full) begin
          load_sr = 1'b1;
          buf_pop = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ccff_shift_en = 1'b1;
        accept_en     = (bit_cnt != LAST_BIT);
        if (bit_cnt == LAST_BIT) begin
          state_d   = DONE;
          buf_flush = 1'b1;
        end else if (bit_idx == LAST_IDX) begin
          if (buf_full) begin
            load_sr = 1'b1;
            buf_pop = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else begin
          shift_sr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, shifter and counters.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q   <= IDLE;
      sr        <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load_sr) begin
        sr      <= buf_data;
        bit_idx <= '0;
      end else if (shift_sr) begin
        sr      <= sr >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (clr_load) begin
        bit_cnt   <= '0;
        stall_cnt <= '0;
      end else begin
        if (ccff_shift_en) bit_cnt <= bit_cnt + 1'b1;
        if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

`ifdef CCFF_READBACK_EN
  // Count ones returning from the chain tail while the chain shifts.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      tail_ones <= '0;
    end else if (clr_load) begin
      tail_ones <= '0;
    end else if (ccff_shift_en && ccff_tail && (tail_ones != '1)) begin
      tail_ones <= tail_ones + 1'b1;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  assign ccff_head = sr[0];
  assign done      = (state_q == DONE);
  assign IO_ISOL_N = (state_q == DONE);

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: two instances (chain 64 and chain 40) share stimulus;
// sel picks the instance under observation.
module tb_ccff_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;

  logic        rdy64, head64, sh64, isol64, done64;
  logic        rdy40, head40, sh40, isol40, done40;
  logic [15:0] st64, st40;
`ifdef CCFF_READBACK_EN
  logic [15:0] tail_ones64, tail_ones40;
`endif

  logic [63:0] chain = '0;
  logic        preload = 1'b0;

  always #5 clk = ~clk;

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(64)) dut64 (
`ifdef CCFF_READBACK_EN
    .tail_ones(tail_ones64),
`endif
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy64), .ccff_head(head64), .ccff_shift_en(sh64),
    .ccff_tail(chain[63]), .IO_ISOL_N(isol64), .done(done64), .stall_cnt(st64)
  );

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut40 (
`ifdef CCFF_READBACK_EN
    .tail_ones(tail_ones40),
`endif
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy40), .ccff_head(head40), .ccff_shift_en(sh40),
    .ccff_tail(1'b0), .IO_ISOL_N(isol40), .done(done40), .stall_cnt(st40)
  );

  logic        rdy, head, sh, isol, dn;
  logic [15:0] stall;
  int          cl_sel;
  assign rdy    = sel ? rdy40  : rdy64;
  assign head   = sel ? head40 : head64;
  assign sh     = sel ? sh40   : sh64;
  assign isol   = sel ? isol40 : isol64;
  assign dn     = sel ? done40 : done64;
  assign stall  = sel ? st40   : st64;
  assign cl_sel = sel ? 40 : 64;

  // Chain model: 64-bit shift register fed by the 64-bit instance.
  always @(posedge clk) begin
    if (preload) chain <= 64'hFF;
    else if (sh64) chain <= {chain[62:0], head64};
  end

  // Observer: captured head bits, shift count, mid-load gap cycles, head stability in gaps.
  bit   cap[$];
  int   shifts = 0, gaps = 0, unstable = 0;
  logic last_head = 1'b0;
  logic mon_clr = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      cap.delete();
      shifts = 0; gaps = 0; unstable = 0;
    end else if (sh) begin
      cap.push_back(head);
      shifts++;
    end else if (shifts > 0 && shifts < cl_sel) begin
      gaps++;
      if (head !== last_head) unstable++;
    end
    last_head = head;
  end

  int checks = 0;
  int failures = 0;

  // Reference: the chain receives the words' bits LSB first, truncated to n bits.
  function automatic int bit_errors(input logic [31:0] words[$], input int n);
    int err = 0;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = words[i / 32];
      if (i >= cap.size()) err++;
      else if (cap[i] !== w[i % 32]) err++;
    end
    return err;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output bit ok);
    bit x;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    in_data = w; in_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      x = rdy;
      @(posedge clk);
      #1;
      if (x) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_shifts(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (shifts >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if ({rdy, head, sh, dn, isol, stall} !== {5'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_vals got rdy=%b head=%b sh=%b done=%b isol=%b stall=%0d want all 0",
               rdy, head, sh, dn, isol, stall);
    end
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b0) begin
        failures++;
        $display("FAIL idle_ready got %b want 0", rdy);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b0;
    do_reset();
    ws = '{32'h0000_0001, 32'h8000_0000};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(64, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      failures++;
      $display("FAIL stream_timeout got ok=%b%b%b want 111", ok1, ok2, ok3);
    end
    @(negedge clk);
    checks++;
    if ({dn, isol, sh, rdy} !== 4'b1100) begin
      failures++;
      $display("FAIL stream_done got done=%b isol=%b sh=%b rdy=%b want 1 1 0 0", dn, isol, sh, rdy);
    end
    checks++;
    if (shifts != 64 || gaps != 0) begin
      failures++;
      $display("FAIL stream_count got shifts=%0d gaps=%0d want 64 0", shifts, gaps);
    end
    checks++;
    if (cap.size() < 64 || cap[0] !== 1'b1 || cap[63] !== 1'b1) begin
      failures++;
      $display("FAIL stream_edges got size=%0d want bit0=1 bit63=1", cap.size());
    end
    checks++;
    if (bit_errors(ws, 64) != 0 || stall !== 16'd0) begin
      failures++;
      $display("FAIL stream_bits got errs=%0d stall=%0d want 0 0", bit_errors(ws, 64), stall);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b0;
    do_reset();
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 36, ok2);
    wait_shifts(64, ok3);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || gaps != 5) begin
      failures++;
      $display("FAIL underflow_gap got ok=%b%b%b gaps=%0d want 111 5", ok1, ok2, ok3, gaps);
    end
    checks++;
    if (stall !== 16'd5) begin
      failures++;
      $display("FAIL underflow_stall got %0d want 5", stall);
    end
    checks++;
    if (unstable != 0 || shifts != 64 || bit_errors(ws, 64) != 0) begin
      failures++;
      $display("FAIL underflow_bits got unstable=%0d shifts=%0d errs=%0d want 0 64 0",
               unstable, shifts, bit_errors(ws, 64));
    end
  endtask

  task automatic test_partial_word();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b1;
    do_reset();
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(40, ok3);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || dn !== 1'b1 || isol !== 1'b1) begin
      failures++;
      $display("FAIL partial_done got ok=%b%b%b done=%b isol=%b want 111 1 1", ok1, ok2, ok3, dn, isol);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (shifts != 40 || bit_errors(ws, 40) != 0 || stall !== 16'd0) begin
      failures++;
      $display("FAIL partial_bits got shifts=%0d errs=%0d stall=%0d want 40 0 0",
               shifts, bit_errors(ws, 40), stall);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b0;
    do_reset();
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(20, ok3);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || {sh, isol, dn, rdy} !== 4'b0000 || stall !== 16'd0) begin
      failures++;
      $display("FAIL midrst_state got ok=%b%b%b sh=%b isol=%b done=%b rdy=%b stall=%0d want 111 0 0 0 0 0",
               ok1, ok2, ok3, sh, isol, dn, rdy, stall);
    end
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(64, ok3);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || shifts != 64 || bit_errors(ws, 64) != 0 || dn !== 1'b1) begin
      failures++;
      $display("FAIL midrst_reload got shifts=%0d errs=%0d done=%b want 64 0 1",
               shifts, bit_errors(ws, 64), dn);
    end
  endtask

  task automatic test_restart();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b0;
    do_reset();
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(10, ok3);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_shifts(64, ok3);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || shifts != 64 || gaps != 0 || bit_errors(ws, 64) != 0 || dn !== 1'b1) begin
      failures++;
      $display("FAIL start_in_shift got shifts=%0d gaps=%0d errs=%0d done=%b want 64 0 0 1",
               shifts, gaps, bit_errors(ws, 64), dn);
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if ({dn, isol, sh, rdy} !== 4'b0001 || stall !== 16'd0) begin
      failures++;
      $display("FAIL restart_from_done got done=%b isol=%b sh=%b rdy=%b stall=%0d want 0 0 0 1 0",
               dn, isol, sh, rdy, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    int g;
    sel = 1'b0;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      ws = '{$urandom, $urandom};
      g = $urandom_range(0, 40);
      mon_clear();
      pulse_start();
      send_word(ws[0], 0, ok1);
      send_word(ws[1], g, ok2);
      wait_shifts(64, ok3);
      @(negedge clk);
      checks++;
      if (!(ok1 && ok2 && ok3) || shifts != 64 || bit_errors(ws, 64) != 0 ||
          stall !== 16'(gaps) || unstable != 0 || dn !== 1'b1) begin
        failures++;
        $display("FAIL b2b_load%0d got shifts=%0d errs=%0d stall=%0d unstable=%0d done=%b want 64 0 %0d 0 1",
                 it, shifts, bit_errors(ws, 64), stall, unstable, dn, gaps);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    logic [31:0] ws[$];
    bit ok1, ok2, ok3;
    sel = 1'b0;
    do_reset();
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    ws = '{$urandom, $urandom};
    mon_clear();
    pulse_start();
    send_word(ws[0], 0, ok1);
    send_word(ws[1], 0, ok2);
    wait_shifts(64, ok3);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || tail_ones64 !== 16'd8) begin
      failures++;
      $display("FAIL readback got tail_ones=%0d want 8", tail_ones64);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_underflow();
    test_partial_word();
    test_reset_mid_shift();
    test_restart();
    test_back_to_back();
`ifdef CCFF_READBACK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
